// File: rtl/coll_pkg.sv
// Shared types and helpers for the all-pairs collision screening sequencer.
package coll_pkg;

   localparam int COLL_W = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_DONE
   } coll_state_t;

   // Object record; its field width sets the coordinate width of the table.
   typedef struct packed {
      logic [COLL_W-1:0] x;
      logic [COLL_W-1:0] y;
      logic [COLL_W-1:0] vx;
      logic [COLL_W-1:0] vy;
   } obj_rec_t;

   function automatic int npair(input int n);
      return n * (n - 1) / 2;
   endfunction

endpackage

// File: rtl/coll_pair_iter.sv
// Walks unordered object pairs (i<j) in row order with a flat pair index p.
module coll_pair_iter
   import coll_pkg::*;
#(
   parameter int N_OBJ = 8,
   parameter int AW    = $clog2(N_OBJ),
   parameter int PW    = (npair(N_OBJ) > 1) ? $clog2(npair(N_OBJ)) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          advance,
   output logic [AW-1:0] i_idx,
   output logic [AW-1:0] j_idx,
   output logic [PW-1:0] p_idx,
   output logic          last
);

   localparam int NPAIR = npair(N_OBJ);

   assign last = (p_idx == PW'(NPAIR - 1));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         i_idx <= '0;
         j_idx <= AW'(1);
         p_idx <= '0;
      end else if (advance && !last) begin
         // end of a row: next row starts one past the new diagonal
         if (j_idx == AW'(N_OBJ - 1)) begin
            i_idx <= i_idx + AW'(1);
            j_idx <= i_idx + AW'(2);
         end else begin
            j_idx <= j_idx + AW'(1);
         end
         p_idx <= p_idx + PW'(1);
      end
   end

endmodule

// File: rtl/coll_pair_sched.sv
// All-pairs collision screening sequencer driving the shared detect datapath.
//   state | meaning
//   IDLE  | table writable, waiting for start
//   ISSUE | operands for (i,j) presented, det_go pulsed
//   WAIT  | waiting for det_done or wait-counter expiry
//   NEXT  | advance pair iterator or finish
//   DONE  | one-cycle done pulse, busy already low
module coll_pair_sched
   import coll_pkg::*;
#(
   parameter  int N_OBJ   = 8,
   parameter  int W       = COLL_W,
   parameter  int TIMEOUT = 64,
   localparam int NPAIR   = npair(N_OBJ),
   localparam int AW      = $clog2(N_OBJ),
   localparam int CW      = $clog2(NPAIR + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             obj_we,
   input  logic [AW-1:0]    obj_addr,
   input  logic [W-1:0]     obj_x,
   input  logic [W-1:0]     obj_y,
   input  logic [W-1:0]     obj_vx,
   input  logic [W-1:0]     obj_vy,
   input  logic [W-1:0]     r2,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [NPAIR-1:0] hit_map,
   output logic [CW-1:0]    hit_count,
   output logic             timeout_err,
   output logic [W-1:0]     det_x1,
   output logic [W-1:0]     det_y1,
   output logic [W-1:0]     det_x2,
   output logic [W-1:0]     det_y2,
   output logic [W-1:0]     det_vx1,
   output logic [W-1:0]     det_vy1,
   output logic [W-1:0]     det_vx2,
   output logic [W-1:0]     det_vy2,
   output logic [W-1:0]     det_r2,
   output logic             det_go,
   input  logic             det_done,
   input  logic             det_hit
);

   localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   coll_state_t   state, state_nx;
   obj_rec_t      tbl [N_OBJ];
   logic [W-1:0]  r2_q;
   logic [TW-1:0] wait_cnt;
   logic          wait_exp;
   logic          it_clear, it_adv, it_last;
   logic [AW-1:0] i_idx, j_idx;
   logic [PW-1:0] p_idx;

   coll_pair_iter #(.N_OBJ(N_OBJ)) u_iter (
      .clock   (clock),
      .reset   (reset),
      .clear   (it_clear),
      .advance (it_adv),
      .i_idx   (i_idx),
      .j_idx   (j_idx),
      .p_idx   (p_idx),
      .last    (it_last)
   );

   // counter holds the number of WAIT cycles already spent on this pair
   assign wait_exp = (wait_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      it_clear = 1'b0;
      it_adv   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_ISSUE;
               it_clear = 1'b1;
            end
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (det_done || wait_exp) state_nx = S_NEXT;
         S_NEXT: begin
            if (it_last) begin
               state_nx = S_DONE;
            end else begin
               it_adv   = 1'b1;
               state_nx = S_ISSUE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);
   assign done   = (state == S_DONE);
   assign det_go = (state == S_ISSUE);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < N_OBJ; k++) tbl[k] <= '0;
      end else if (obj_we && (state == S_IDLE) && (int'(obj_addr) < N_OBJ)) begin
         tbl[obj_addr] <= '{x: obj_x, y: obj_y, vx: obj_vx, vy: obj_vy};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r2_q        <= '0;
         hit_map     <= '0;
         hit_count   <= '0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  r2_q        <= r2;
                  hit_map     <= '0;
                  hit_count   <= '0;
                  timeout_err <= 1'b0;
               end
            end
            S_ISSUE: wait_cnt <= '0;
            S_WAIT: begin
               wait_cnt <= wait_cnt + TW'(1);
               // a result arriving on the expiry cycle wins over the timeout
               if (det_done) begin
                  hit_map[p_idx] <= det_hit;
                  if (det_hit) hit_count <= hit_count + CW'(1);
               end else if (wait_exp) begin
                  timeout_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // table is frozen while busy and i/j only move in NEXT, so operands hold through WAIT
   assign det_x1  = tbl[i_idx].x;
   assign det_y1  = tbl[i_idx].y;
   assign det_vx1 = tbl[i_idx].vx;
   assign det_vy1 = tbl[i_idx].vy;
   assign det_x2  = tbl[j_idx].x;
   assign det_y2  = tbl[j_idx].y;
   assign det_vx2 = tbl[j_idx].vx;
   assign det_vy2 = tbl[j_idx].vy;
   assign det_r2  = r2_q;

endmodule

// File: tb/tb_coll_pair_sched.sv
// Scoreboard bench: expected issues/results queued at start, monitor pops on det_go/done.
module tb_coll_pair_sched;

   localparam int N_OBJ   = 8;
   localparam int W       = 16;
   localparam int TIMEOUT = 64;
   localparam int NP      = N_OBJ * (N_OBJ - 1) / 2;

   logic          clock, reset, obj_we, start;
   logic [2:0]    obj_addr;
   logic [W-1:0]  obj_x, obj_y, obj_vx, obj_vy, r2;
   logic          busy, done, timeout_err, det_go, det_done, det_hit;
   logic [NP-1:0] hit_map;
   logic [4:0]    hit_count;
   logic [W-1:0]  det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2;

   coll_pair_sched #(.N_OBJ(N_OBJ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .obj_we(obj_we), .obj_addr(obj_addr),
      .obj_x(obj_x), .obj_y(obj_y), .obj_vx(obj_vx), .obj_vy(obj_vy),
      .r2(r2), .start(start), .busy(busy), .done(done), .hit_map(hit_map),
      .hit_count(hit_count), .timeout_err(timeout_err),
      .det_x1(det_x1), .det_y1(det_y1), .det_x2(det_x2), .det_y2(det_y2),
      .det_vx1(det_vx1), .det_vy1(det_vy1), .det_vx2(det_vx2), .det_vy2(det_vy2),
      .det_r2(det_r2), .det_go(det_go), .det_done(det_done), .det_hit(det_hit)
   );

   typedef struct {
      logic [W-1:0] x1, y1, vx1, vy1, x2, y2, vx2, vy2, r2;
   } iss_t;
   typedef struct {
      logic [NP-1:0] map;
      int            cnt;
      bit            to;
      int            start_cyc;
      int            dur;
   } res_t;

   iss_t         iss_q[$];
   res_t         res_q[$];
   logic [W-1:0] mx[N_OBJ], my[N_OBJ], mvx[N_OBJ], mvy[N_OBJ];
   int           lat[NP];
   bit           plan_hit[NP];
   bit           spur[NP];
   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
   endtask

   // monitor: compares every issue and every sweep end against the queues
   initial begin
      iss_t e;
      res_t r;
      forever begin
         @(negedge clock);
         if (reset === 1'b0) begin
            if (det_go) begin
               if (iss_q.size() == 0) fail_event("unexpected_det_go");
               else begin
                  e = iss_q.pop_front();
                  check("x1", 64'(det_x1), 64'(e.x1));   check("y1", 64'(det_y1), 64'(e.y1));
                  check("vx1", 64'(det_vx1), 64'(e.vx1)); check("vy1", 64'(det_vy1), 64'(e.vy1));
                  check("x2", 64'(det_x2), 64'(e.x2));   check("y2", 64'(det_y2), 64'(e.y2));
                  check("vx2", 64'(det_vx2), 64'(e.vx2)); check("vy2", 64'(det_vy2), 64'(e.vy2));
                  check("r2", 64'(det_r2), 64'(e.r2));
                  check("busy_at_go", 64'(busy), 64'd1);
               end
            end
            if (done) begin
               if (res_q.size() == 0) fail_event("unexpected_done");
               else begin
                  r = res_q.pop_front();
                  check("hit_map", 64'(hit_map), 64'(r.map));
                  check("hit_count", 64'(hit_count), 64'(r.cnt));
                  check("timeout_err", 64'(timeout_err), 64'(r.to));
                  check("busy_at_done", 64'(busy), 64'd0);
                  check("done_cycle", 64'(cyc - r.start_cyc), 64'(r.dur));
               end
            end
         end
      end
   end

   // datapath model: answers det_go of pair p after lat[p] cycles (0 = never)
   initial begin
      int  rp, rcnt;
      bit  ract, rhit;
      det_done = 1'b0; det_hit = 1'b0;
      rp = 0; rcnt = 0; ract = 0; rhit = 0;
      forever begin
         @(negedge clock);
         det_done = 1'b0;
         det_hit  = 1'b0;
         if (reset || (start && !busy)) begin
            rp = 0;
            ract = 0;
         end else begin
            if (ract) begin
               rcnt--;
               if (rcnt == 0) begin
                  det_done = 1'b1;
                  det_hit  = rhit;
                  ract     = 0;
               end
            end
            if (det_go) begin
               if (rp < NP) begin
                  if (lat[rp] > 0) begin
                     ract = 1; rcnt = lat[rp]; rhit = plan_hit[rp];
                  end
                  if (spur[rp]) begin
                     det_done = 1'b1;
                     det_hit  = 1'b1;
                  end
               end
               rp++;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic write_obj(input int a, input bit upd);
      logic [W-1:0] x, y, vx, vy;
      x = W'($urandom); y = W'($urandom); vx = W'($urandom); vy = W'($urandom);
      obj_addr = 3'(a); obj_x = x; obj_y = y; obj_vx = vx; obj_vy = vy; obj_we = 1'b1;
      @(posedge clock); #1;
      obj_we = 1'b0;
      if (upd) begin
         mx[a] = x; my[a] = y; mvx[a] = vx; mvy[a] = vy;
      end
   endtask

   task automatic gen_plan(input bit special);
      for (int p = 0; p < NP; p++) begin
         lat[p] = $urandom_range(1, 6);
         plan_hit[p] = 1'($urandom_range(0, 1));
         spur[p] = 1'b0;
         if (special && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
               0:       lat[p] = 0;
               1:       lat[p] = TIMEOUT;
               default: lat[p] = TIMEOUT + 1;
            endcase
         end
      end
   endtask

   // reference: walk i<j pairs, result is valid only if answered within TIMEOUT WAIT cycles
   task automatic launch(input logic [W-1:0] r2v, input int n_issue, input bit want_res);
      res_t rr;
      iss_t e;
      int   p;
      rr.map = '0; rr.cnt = 0; rr.to = 0; rr.dur = 0;
      rr.start_cyc = cyc + 1;
      p = 0;
      for (int i = 0; i < N_OBJ - 1; i++) begin
         for (int j = i + 1; j < N_OBJ; j++) begin
            if (p < n_issue) begin
               e.x1 = mx[i]; e.y1 = my[i]; e.vx1 = mvx[i]; e.vy1 = mvy[i];
               e.x2 = mx[j]; e.y2 = my[j]; e.vx2 = mvx[j]; e.vy2 = mvy[j];
               e.r2 = r2v;
               iss_q.push_back(e);
            end
            if (lat[p] >= 1 && lat[p] <= TIMEOUT) begin
               if (plan_hit[p]) begin
                  rr.map[p] = 1'b1;
                  rr.cnt++;
               end
               rr.dur += lat[p] + 2;
            end else begin
               rr.to = 1;
               rr.dur += TIMEOUT + 2;
            end
            p++;
         end
      end
      if (want_res) res_q.push_back(rr);
      r2 = r2v;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      r2 = W'($urandom);
   endtask

   task automatic wait_sweep(input bit disturb);
      int k;
      k = 0;
      while (res_q.size() != 0 && k < 3000) begin
         if (disturb && k == 5) begin
            obj_addr = 3'($urandom_range(0, N_OBJ - 1));
            obj_x = W'($urandom); obj_y = W'($urandom);
            obj_vx = W'($urandom); obj_vy = W'($urandom);
            obj_we = 1'b1;
            start  = 1'b1;
         end else begin
            obj_we = 1'b0;
            start  = 1'b0;
         end
         @(posedge clock); #1;
         k++;
      end
      obj_we = 1'b0;
      start  = 1'b0;
      if (res_q.size() != 0) begin
         fail_event("sweep_budget");
         res_q.delete();
      end
      check("issue_drain", 64'(iss_q.size()), 64'd0);
      iss_q.delete();
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      int k;
      reset = 1'b1; obj_we = 1'b0; start = 1'b0; obj_addr = '0;
      obj_x = '0; obj_y = '0; obj_vx = '0; obj_vy = '0; r2 = '0;
      for (int a = 0; a < N_OBJ; a++) begin
         mx[a] = '0; my[a] = '0; mvx[a] = '0; mvy[a] = '0;
      end
      gen_plan(0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_det_go", 64'(det_go), 64'd0);
      check("rst_hit_map", 64'(hit_map), 64'd0);
      check("rst_hit_count", 64'(hit_count), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check("rst_det_x1", 64'(det_x1), 64'd0);
      check("rst_det_vy2", 64'(det_vy2), 64'd0);
      check("rst_det_r2", 64'(det_r2), 64'd0);
      @(posedge clock); #1;

      for (int a = 0; a < N_OBJ; a++) write_obj(a, 1);

      // fixed latency, single hit on (0,2)
      gen_plan(0);
      for (int p = 0; p < NP; p++) begin
         lat[p] = 11;
         plan_hit[p] = (p == 1);
      end
      launch(W'($urandom), NP, 1);
      wait_sweep(0);

      // every pair hits
      gen_plan(0);
      for (int p = 0; p < NP; p++) plan_hit[p] = 1'b1;
      launch(W'($urandom), NP, 1);
      wait_sweep(0);

      // p5 never answered, p3 answered on expiry cycle, p9 answered one cycle late
      gen_plan(0);
      lat[5] = 0; plan_hit[5] = 1'b1;
      lat[3] = TIMEOUT; plan_hit[3] = 1'b1;
      lat[9] = TIMEOUT + 1; plan_hit[9] = 1'b1;
      launch(W'($urandom), NP, 1);
      wait_sweep(0);

      // only the coincident result: timeout_err must stay low
      gen_plan(0);
      lat[12] = TIMEOUT; plan_hit[12] = 1'b1;
      launch(W'($urandom), NP, 1);
      wait_sweep(0);

      // writes and start while busy, spurious det_done during ISSUE
      gen_plan(0);
      for (int p = 0; p < NP; p += 3) spur[p] = 1'b1;
      launch(W'($urandom), NP, 1);
      wait_sweep(1);
      gen_plan(0);
      launch(W'($urandom), NP, 1);
      wait_sweep(0);

      // reset while waiting on p10
      gen_plan(0);
      lat[10] = 40;
      launch(W'($urandom), 11, 0);
      k = 0;
      while (iss_q.size() != 0 && k < 500) begin
         @(posedge clock); #1;
         k++;
      end
      if (iss_q.size() != 0) fail_event("reach_p10");
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      iss_q.delete();
      for (int a = 0; a < N_OBJ; a++) begin
         mx[a] = '0; my[a] = '0; mvx[a] = '0; mvy[a] = '0;
      end
      @(negedge clock);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hit_map", 64'(hit_map), 64'd0);
      check("abort_hit_count", 64'(hit_count), 64'd0);
      check("abort_det_go", 64'(det_go), 64'd0);
      @(posedge clock); #1;
      repeat (5) @(posedge clock);
      #1;

      // fresh sweep after reset; table was cleared except what is rewritten here
      write_obj(2, 1);
      write_obj(6, 1);
      gen_plan(0);
      launch(W'($urandom), NP, 1);
      wait_sweep(0);

      // randomized sweeps with occasional timeouts and table updates
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 3; w++) write_obj($urandom_range(0, N_OBJ - 1), 1);
         gen_plan(1);
         if (s % 3 == 1) for (int p = 0; p < NP; p++) spur[p] = 1'($urandom_range(0, 1));
         launch(W'($urandom), NP, 1);
         wait_sweep(s % 2 == 0);
      end

      repeat (5) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
